// File: rtl/log_unpacked_to_linear_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Package : LogLinearDef
// Brief   : Derived widths, ROM-entry generator and stage payload for the
//           log-to-linear converter.
// Rev     : 1.0  initial release
// ============================================================================
package LogLinearDef;

  function automatic int getSignedExponentBits(input int width, input int ls);
    return $clog2(((width - 2) << ls) + 1) + 1;
  endfunction

  function automatic int getFractionBits(input int width, input int ls);
    return width - 3 - ls;
  endfunction

  function automatic longint unsigned isqrt(input longint unsigned x);
    longint unsigned rem  = x;
    longint unsigned res  = 64'd0;
    longint unsigned bitv = 64'd1 << 62;
    while (bitv > rem) bitv = bitv >> 2;
    while (bitv != 64'd0) begin
      if (rem >= res + bitv) begin
        rem = rem - (res + bitv);
        res = (res >> 1) + bitv;
      end else begin
        res = res >> 1;
      end
      bitv = bitv >> 2;
    end
    return res;
  endfunction

  // round(2^(i/2^f) * 2^lut_frac), built from repeated square roots of 2 in Q30
  function automatic int lutEntry(input int i, input int f, input int lut_frac);
    longint unsigned root = 64'd2 << 30;
    longint unsigned acc  = 64'd1 << 30;
    for (int k = 1; k <= f; k++) begin
      root = isqrt(root << 30);
      if (((i >> (f - k)) & 1) != 0) acc = (acc * root + (64'd1 << 29)) >> 30;
    end
    return int'((acc + (64'd1 << (29 - lut_frac))) >> (30 - lut_frac));
  endfunction

  localparam int c_width    = 8;
  localparam int c_ls       = 1;
  localparam int c_m        = getSignedExponentBits(c_width, c_ls);
  localparam int c_f        = getFractionBits(c_width, c_ls);
  localparam int c_lut_frac = c_f + 4;
  localparam int c_acc_int  = 8;
  localparam int c_acc_frac = 8;
  localparam int c_out_w    = c_acc_int + c_acc_frac;
  localparam int c_mant_w   = c_lut_frac + 1;
  localparam int c_sh_w     = c_m + $clog2(c_acc_frac + c_lut_frac + 1) + 1;

  typedef struct packed {
    logic                     valid;
    logic                     sign;
    logic                     is_inf;
    logic                     is_zero;
    logic signed [c_sh_w-1:0] sh;
    logic [c_mant_w-1:0]      mant;
  } stage_t;

endpackage
`default_nettype wire

// File: rtl/log_unpacked_to_linear_pipe_if.sv
`default_nettype none
// ============================================================================
// Interface : log_unpacked_to_linear_pipe_if
// Brief     : Input and output streams of the log-to-linear converter.
// Rev       : 1.0  initial release
// ============================================================================
interface log_unpacked_to_linear_pipe_if
  import LogLinearDef::*;
#(
  parameter int M     = c_m,
  parameter int F     = c_f,
  parameter int OUT_W = c_out_w
);
  logic                in_valid;
  logic                in_ready;
  logic                in_sign;
  logic                in_isInf;
  logic                in_isZero;
  logic signed [M-1:0] in_signedLogExp;
  logic [F-1:0]        in_logFrac;
  logic                out_valid;
  logic                out_ready;
  logic [OUT_W-1:0]    out_data;
  logic                out_sat;

  modport master (
    output in_valid, in_sign, in_isInf, in_isZero, in_signedLogExp, in_logFrac, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );

  modport slave (
    input  in_valid, in_sign, in_isInf, in_isZero, in_signedLogExp, in_logFrac, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );
endinterface
`default_nettype wire

// File: rtl/log_unpacked_to_linear_pipe_lut.sv
`default_nettype none
// ============================================================================
// Module : log_frac_pow2_lut
// Brief  : Combinational ROM returning 2^(idx/2^F) with LUT_FRAC fraction bits.
// Rev    : 1.0  initial release
// ============================================================================
module log_frac_pow2_lut
  import LogLinearDef::*;
#(
  parameter int F        = c_f,
  parameter int LUT_FRAC = F + 4
) (
  input  wire logic [F-1:0]    i_idx,
  output logic      [LUT_FRAC:0] o_mant
);
  logic [LUT_FRAC:0] w_table [0:(1 << F) - 1];

  for (genvar i = 0; i < (1 << F); i++) begin : g_rom
    localparam int c_val = lutEntry(i, F, LUT_FRAC);
    assign w_table[i] = c_val[LUT_FRAC:0];
  end

  assign o_mant = w_table[i_idx];
endmodule
`default_nettype wire

// File: rtl/log_unpacked_to_linear_pipe.sv
`default_nettype none
// ============================================================================
// Module : log_unpacked_to_linear_pipe
// Brief  : 3-stage unpacked-log to saturating fixed-point linear converter.
// Rev    : 1.0  initial release
// ============================================================================
module log_unpacked_to_linear_pipe
  import LogLinearDef::*;
#(
  parameter int WIDTH    = c_width,
  parameter int LS       = c_ls,
  parameter int LUT_FRAC = getFractionBits(WIDTH, LS) + 4,
  parameter int ACC_INT  = c_acc_int,
  parameter int ACC_FRAC = c_acc_frac
) (
  input  wire logic                   clock,
  input  wire logic                   reset,
  log_unpacked_to_linear_pipe_if.slave bus
);
  localparam int c_exp_w  = getSignedExponentBits(WIDTH, LS);
  localparam int c_frac_w = getFractionBits(WIDTH, LS);
  localparam int c_mnt_w  = LUT_FRAC + 1;
  localparam int c_res_w  = ACC_INT + ACC_FRAC;
  localparam int c_shw    = c_exp_w + $clog2(ACC_FRAC + LUT_FRAC + 1) + 1;
  localparam int c_wide_w = c_mnt_w + c_res_w;
  localparam logic [c_wide_w-1:0] c_max_wide = {{(c_mnt_w + 1){1'b0}}, {(c_res_w - 1){1'b1}}};
  localparam logic [c_res_w-1:0]  c_max_res  = {1'b0, {(c_res_w - 1){1'b1}}};

  logic                      w_advance;
  logic                      r_s1_valid;
  logic                      r_s1_sign;
  logic                      r_s1_inf;
  logic                      r_s1_zero;
  logic signed [c_exp_w-1:0] r_s1_exp;
  logic [c_frac_w-1:0]       r_s1_frac;
  logic [c_mnt_w-1:0]        w_mant;
  logic signed [c_shw-1:0]   w_sh;
  stage_t                    w_s2_next;
  stage_t                    r_s2;
  logic [c_wide_w-1:0]       w_mag;
  logic [c_shw-1:0]          w_rsh;
  logic                      w_big;
  logic                      w_ovf;
  logic [c_res_w-1:0]        w_res_mag;
  logic [c_res_w-1:0]        w_res;
  logic                      w_sat;
  logic                      r_out_valid;
  logic [c_res_w-1:0]        r_out_data;
  logic                      r_out_sat;

  // The whole pipe moves as one: any stall at the output freezes every stage.
  assign w_advance     = !r_out_valid || bus.out_ready;
  assign bus.in_ready  = w_advance;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_sat   = r_out_sat;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_sign  <= 1'b0;
      r_s1_inf   <= 1'b0;
      r_s1_zero  <= 1'b0;
      r_s1_exp   <= '0;
      r_s1_frac  <= '0;
    end else if (w_advance) begin
      r_s1_valid <= bus.in_valid;
      r_s1_sign  <= bus.in_sign;
      r_s1_inf   <= bus.in_isInf;
      r_s1_zero  <= bus.in_isZero;
      r_s1_exp   <= bus.in_signedLogExp;
      r_s1_frac  <= bus.in_logFrac;
    end
  end

  log_frac_pow2_lut #(
    .F        (c_frac_w),
    .LUT_FRAC (LUT_FRAC)
  ) u_lut (
    .i_idx  (r_s1_frac),
    .o_mant (w_mant)
  );

  assign w_sh = c_shw'(r_s1_exp) + c_shw'(ACC_FRAC) - c_shw'(LUT_FRAC);

  always_comb begin
    w_s2_next         = '0;
    w_s2_next.valid   = r_s1_valid;
    w_s2_next.sign    = r_s1_sign;
    w_s2_next.is_inf  = r_s1_inf;
    w_s2_next.is_zero = r_s1_zero;
    w_s2_next.sh      = w_sh;
    w_s2_next.mant    = w_mant;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_s2 <= '0;
    end else if (w_advance) begin
      r_s2 <= w_s2_next;
    end
  end

  // mant has its top bit set, so any left shift reaching the sign position overflows.
  always_comb begin
    w_mag = '0;
    w_rsh = '0;
    w_big = 1'b0;
    if (!r_s2.sh[c_shw-1]) begin
      if (r_s2.sh > c_shw'(c_res_w - 1)) begin
        w_big = 1'b1;
      end else begin
        w_mag = c_wide_w'(r_s2.mant) << r_s2.sh;
      end
    end else begin
      w_rsh = -r_s2.sh;
      if (w_rsh < c_shw'(LUT_FRAC + 2)) begin
        w_mag = (c_wide_w'(r_s2.mant) + (c_wide_w'(1) << (w_rsh - c_shw'(1)))) >> w_rsh;
      end
    end
  end

  assign w_ovf = w_big || (w_mag > c_max_wide);

  always_comb begin
    w_sat     = 1'b0;
    w_res_mag = w_mag[c_res_w-1:0];
    if (r_s2.is_inf || w_ovf) begin
      w_sat     = 1'b1;
      w_res_mag = c_max_res;
    end
    if (r_s2.is_zero && !r_s2.is_inf) begin
      w_sat     = 1'b0;
      w_res_mag = '0;
    end
    w_res = r_s2.sign ? -w_res_mag : w_res_mag;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sat   <= 1'b0;
    end else if (w_advance) begin
      r_out_valid <= r_s2.valid;
      r_out_data  <= w_res;
      r_out_sat   <= w_sat;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_log_unpacked_to_linear_pipe.sv
`default_nettype none
// ============================================================================
// Module : tb_log_unpacked_to_linear_pipe
// Brief  : Self-checking bench: directed table, stall pattern, random stream.
// Rev    : 1.0  initial release
// ============================================================================
module tb_log_unpacked_to_linear_pipe;
  import LogLinearDef::*;

  localparam int c_max = (1 << (c_out_w - 1)) - 1;

  typedef struct packed {
    logic [c_out_w-1:0] d;
    logic               sat;
  } exp_t;

  typedef struct {
    int                 e;
    int                 f;
    bit                 s;
    bit                 inf;
    bit                 zero;
    logic [c_out_w-1:0] d;
    bit                 sat;
  } vec_t;

  logic clock = 1'b0;
  logic reset;

  log_unpacked_to_linear_pipe_if #(.M(c_m), .F(c_f), .OUT_W(c_out_w)) bus ();

  log_unpacked_to_linear_pipe dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int                 vectors     = 0;
  int                 miscompares = 0;
  exp_t               exp_q[$];
  exp_t               drv_exp;
  bit                 was_stalled = 1'b0;
  logic [c_out_w-1:0] held_data;
  int                 out_cnt     = 0;
  vec_t               vec[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Reference: round the table entry, then scale by a power of two and round again.
  function automatic exp_t model(input int e, input int f, input bit s, input bit inf, input bit zero);
    exp_t r;
    real  mag_r;
    int   mant;
    int   mag;
    r.sat = 1'b0;
    mag   = 0;
    if (inf) begin
      mag   = c_max;
      r.sat = 1'b1;
    end else if (!zero) begin
      mant  = $rtoi(2.0 ** (real'(f) / real'(1 << c_f)) * real'(1 << c_lut_frac) + 0.5);
      mag_r = real'(mant) * 2.0 ** real'(e + c_acc_frac - c_lut_frac);
      if (mag_r >= real'(c_max) + 0.5) begin
        mag   = c_max;
        r.sat = 1'b1;
      end else begin
        mag = $rtoi(mag_r + 0.5);
      end
    end
    r.d = c_out_w'(s ? -mag : mag);
    return r;
  endfunction

  task automatic set_fields(input int e, input int f, input bit s, input bit inf, input bit zero);
    bus.in_signedLogExp = c_m'(e);
    bus.in_logFrac      = c_f'(f);
    bus.in_sign         = s;
    bus.in_isInf        = inf;
    bus.in_isZero       = zero;
  endtask

  task automatic new_beat();
    int e, f;
    bit s, inf, zero;
    e    = int'($urandom_range(0, (1 << c_m) - 1)) - (1 << (c_m - 1));
    f    = int'($urandom_range(0, (1 << c_f) - 1));
    s    = 1'($urandom_range(0, 1));
    inf  = ($urandom_range(0, 15) == 0);
    zero = ($urandom_range(0, 15) == 0);
    set_fields(e, f, s, inf, zero);
    drv_exp = model(e, f, s, inf, zero);
  endtask

  // One clock: observe at the falling edge, then advance to just after the rising edge.
  task automatic step(output bit acc);
    exp_t got;
    @(negedge clock);
    check("in_ready", 32'(bus.in_ready), 32'(!bus.out_valid || bus.out_ready));
    if (was_stalled) begin
      check("hold_data", 32'(bus.out_data), 32'(held_data));
      check("hold_valid", 32'(bus.out_valid), 32'd1);
    end
    was_stalled = bus.out_valid && !bus.out_ready;
    held_data   = bus.out_data;
    if (bus.out_valid && bus.out_ready) begin
      out_cnt++;
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL extra_output: got 0x%0h, required no beat", bus.out_data);
      end else begin
        got = exp_q.pop_front();
        check("out_data", 32'(bus.out_data), 32'(got.d));
        check("out_sat", 32'(bus.out_sat), 32'(got.sat));
      end
    end
    acc = bus.in_valid && bus.in_ready;
    if (acc) exp_q.push_back(drv_exp);
    @(posedge clock);
    #1;
  endtask

  task automatic drain(input string name);
    bit acc;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) step(acc);
    check({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  // Edges are counted with the accepting edge as the first.
  task automatic latency_probe(input string name);
    int edges;
    set_fields(2, 8, 1'b0, 1'b0, 1'b0);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
    edges = 1;
    while (!bus.out_valid && edges < 10) begin
      @(posedge clock);
      #1;
      edges++;
    end
    check({name, "_latency"}, 32'(edges), 32'd3);
    check({name, "_data"}, 32'(bus.out_data), 32'h05A8);
    @(posedge clock);
    #1;
    check({name, "_consumed"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    bit acc;
    int sent, c;
    bit [3:0] pat;

    vec[0]  = '{0,   0,  1'b0, 1'b0, 1'b0, 16'h0100, 1'b0};
    vec[1]  = '{2,   8,  1'b0, 1'b0, 1'b0, 16'h05A8, 1'b0};
    vec[2]  = '{2,   8,  1'b1, 1'b0, 1'b0, 16'hFA58, 1'b0};
    vec[3]  = '{-9,  0,  1'b0, 1'b0, 1'b0, 16'h0001, 1'b0};
    vec[4]  = '{-10, 0,  1'b0, 1'b0, 1'b0, 16'h0000, 1'b0};
    vec[5]  = '{7,   0,  1'b0, 1'b0, 1'b0, 16'h7FFF, 1'b1};
    vec[6]  = '{0,   0,  1'b1, 1'b1, 1'b0, 16'h8001, 1'b1};
    vec[7]  = '{3,   5,  1'b1, 1'b0, 1'b1, 16'h0000, 1'b0};
    vec[8]  = '{0,   0,  1'b0, 1'b1, 1'b1, 16'h7FFF, 1'b1};
    vec[9]  = '{6,   15, 1'b0, 1'b0, 1'b0, 16'h7A80, 1'b0};
    vec[10] = '{-1,  0,  1'b1, 1'b0, 1'b0, 16'hFF80, 1'b0};
    vec[11] = '{-9,  8,  1'b0, 1'b0, 1'b0, 16'h0001, 1'b0};
    vec[12] = '{-10, 15, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0};
    vec[13] = '{15,  3,  1'b1, 1'b0, 1'b0, 16'h8001, 1'b1};

    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    set_fields(0, 0, 1'b0, 1'b0, 1'b0);
    drv_exp = '0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
    check("rst_out_sat", 32'(bus.out_sat), 32'd0);
    reset = 1'b0;
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clock);
    #1;

    latency_probe("first");

    bus.out_ready = 1'b1;
    foreach (vec[i]) begin
      set_fields(vec[i].e, vec[i].f, vec[i].s, vec[i].inf, vec[i].zero);
      drv_exp      = '{vec[i].d, vec[i].sat};
      bus.in_valid = 1'b1;
      step(acc);
      check("table_accept", 32'(acc), 32'd1);
    end
    drain("table");

    // Back-to-back beats against an output stalling in a 1,0,0,1 rhythm.
    pat     = 4'b1001;
    sent    = 0;
    c       = 0;
    out_cnt = 0;
    new_beat();
    bus.in_valid = 1'b1;
    while (sent < 10 && c < 100) begin
      bus.out_ready = pat[c % 4];
      step(acc);
      c++;
      if (acc) begin
        sent++;
        if (sent < 10) new_beat();
        else bus.in_valid = 1'b0;
      end
    end
    check("stall_sent", 32'(sent), 32'd10);
    drain("stall");
    check("stall_out_count", 32'(out_cnt), 32'd10);

    for (int i = 0; i < 300; i++) begin
      if (!bus.in_valid || acc) begin
        new_beat();
        bus.in_valid = ($urandom_range(0, 3) != 0);
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      step(acc);
    end
    drain("random");

    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      new_beat();
      bus.in_valid = 1'b1;
      step(acc);
    end
    bus.in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_out_data", 32'(bus.out_data), 32'd0);
    exp_q.delete();
    was_stalled = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("midrst_flushed", 32'(bus.out_valid), 32'd0);
    latency_probe("after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: got no completion, required finish");
    $fatal(1);
  end
endmodule
`default_nettype wire
